// File: rtl/mux_serializer_ctrl_pkg.sv
// Shared types and index helpers for the parallel-in/serial-out mux controller.
// Start and end indices depend only on bit order and word width.
package mux_serializer_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int start_idx(input bit msb_first, input int width);
    return msb_first ? width - 1 : 0;
  endfunction

  function automatic int end_idx(input bit msb_first, input int width);
    return msb_first ? 0 : width - 1;
  endfunction

endpackage

// File: rtl/mux_serializer_ctrl_if.sv
// Word-in / bit-out handshake bundle for mux_serializer_ctrl.
// The slave modport is the controller; the master modport is the word source and bit consumer.
interface mux_serializer_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int SEL_W = $clog2(WIDTH);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [SEL_W-1:0] sel;
  logic             busy;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_bit, out_valid, out_last, sel, busy
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_bit, out_valid, out_last, sel, busy
  );
endinterface

// File: rtl/mux_serializer_ctrl_bit_select_mux.sv
// Combinational WIDTH:1 bit-select mux, identical to the standalone downstream mux stage.
module bit_select_mux #(
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SEL_W-1:0] sel,
  output logic             out_bit
);
  assign out_bit = data[sel];
endmodule

// File: rtl/mux_serializer_ctrl.sv
// Holds one parallel word and walks the mux select across it, one bit per accepted beat.
// The last beat can reload the next word directly, so consecutive words have no bubble.
//
// state | meaning
// IDLE  | no word held, ready for a new word
// SHIFT | word held, presenting hold_q[sel_q] on the serial output
module mux_serializer_ctrl
  import mux_serializer_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_serializer_ctrl_if.slave bus
);
  localparam int SEL_W = $clog2(WIDTH);
  localparam logic [SEL_W-1:0] START = SEL_W'(start_idx(MSB_FIRST, WIDTH));
  localparam logic [SEL_W-1:0] STOP  = SEL_W'(end_idx(MSB_FIRST, WIDTH));
  localparam logic [SEL_W-1:0] ONE   = SEL_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             out_valid, out_last, in_ready, accept, beat;
  logic             mux_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      sel_q   <= START;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    sel_d     = sel_q;
    out_valid = (state_q == SHIFT);
    out_last  = out_valid && (sel_q == STOP);
    // in_ready looks only at out_ready, never at in_valid
    in_ready  = (state_q == IDLE) || (out_last && bus.out_ready);
    accept    = bus.in_valid && in_ready;
    beat      = out_valid && bus.out_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d  = bus.in_data;
          sel_d   = START;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (beat) begin
          if (!out_last) begin
            sel_d = MSB_FIRST ? (sel_q - ONE) : (sel_q + ONE);
          end else if (bus.in_valid) begin
            hold_d = bus.in_data;
            sel_d  = START;
          end else begin
            sel_d   = START;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = START;
      end
    endcase
  end

  bit_select_mux #(
    .WIDTH(WIDTH),
    .SEL_W(SEL_W)
  ) u_mux (
    .data   (hold_q),
    .sel    (sel_q),
    .out_bit(mux_bit)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_bit   = mux_bit;
  assign bus.sel       = sel_q;
  assign bus.busy      = out_valid;

endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// Scoreboard bench: one LSB-first and one MSB-first controller share identical stimulus;
// a per-word reference model pushes expected beats, a negedge monitor pops and compares.
module tb_mux_serializer_ctrl;

  typedef struct packed {
    logic       b;
    logic       last;
    logic [2:0] sel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  int         rdy_mode = 0;
  int         vectors = 0;
  int         miscompares = 0;

  exp_t q[2][$];

  logic       ir[2], ov[2], ol[2], ob[2], bz[2];
  logic [2:0] sl[2];

  mux_serializer_ctrl_if #(.WIDTH(8)) ifa ();
  mux_serializer_ctrl_if #(.WIDTH(8)) ifb ();

  assign ifa.in_data   = in_data;
  assign ifa.in_valid  = in_valid;
  assign ifa.out_ready = out_ready;
  assign ifb.in_data   = in_data;
  assign ifb.in_valid  = in_valid;
  assign ifb.out_ready = out_ready;

  assign ir[0] = ifa.in_ready;  assign ir[1] = ifb.in_ready;
  assign ov[0] = ifa.out_valid; assign ov[1] = ifb.out_valid;
  assign ol[0] = ifa.out_last;  assign ol[1] = ifb.out_last;
  assign ob[0] = ifa.out_bit;   assign ob[1] = ifb.out_bit;
  assign bz[0] = ifa.busy;      assign bz[1] = ifb.busy;
  assign sl[0] = ifa.sel;       assign sl[1] = ifb.sel;

  mux_serializer_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  mux_serializer_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  // Reference model: a word becomes 8 beats, walked from the start bit to the end bit.
  task automatic push_word(input int d, input logic [7:0] w);
    exp_t e;
    int   idx;
    for (int k = 0; k < 8; k++) begin
      idx    = (d == 1) ? 7 - k : k;
      e.b    = w[idx];
      e.last = (k == 7);
      e.sel  = 3'(idx);
      q[d].push_back(e);
    end
  endtask

  always @(negedge clk) begin
    logic exp_rdy;
    exp_t f;
    if (!rst_n) begin
      q[0].delete();
      q[1].delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        exp_rdy = (q[d].size() == 0) || (q[d][0].last && out_ready);
        check("in_ready", d, {7'b0, ir[d]}, {7'b0, exp_rdy});
        check("out_valid", d, {7'b0, ov[d]}, {7'b0, q[d].size() != 0});
        check("busy", d, {7'b0, bz[d]}, {7'b0, q[d].size() != 0});
        if (q[d].size() != 0) begin
          f = q[d][0];
          check("out_bit", d, {7'b0, ob[d]}, {7'b0, f.b});
          check("out_last", d, {7'b0, ol[d]}, {7'b0, f.last});
          check("sel", d, {5'b0, sl[d]}, {5'b0, f.sel});
          if (out_ready) void'(q[d].pop_front());
        end else begin
          check("out_last_idle", d, {7'b0, ol[d]}, 8'h00);
        end
        if (in_valid && exp_rdy) push_word(d, in_data);
      end
    end
  end

  int pcnt = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = (pcnt % 3 == 0); pcnt++; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send_word(input logic [7:0] w);
    bit done = 0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (ifa.in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL send_timeout: word %0h not accepted within 200 cycles", w);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!ifa.out_valid && !ifb.out_valid) done = 1;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL idle_timeout: out_valid still high after 300 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with a word offered; nothing may be captured.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_sel", 0, {5'b0, ifa.sel}, 8'd0);
    check("rst_sel", 1, {5'b0, ifb.sel}, 8'd7);
    check("rst_out_bit", 0, {7'b0, ifa.out_bit}, 8'd0);
    check("rst_out_bit", 1, {7'b0, ifb.out_bit}, 8'd0);
    check("rst_in_ready", 0, {7'b0, ifa.in_ready}, 8'd1);
    @(posedge clk);
    #1;

    rdy_mode = 0;
    send_word(8'hA5);
    wait_idle();

    rdy_mode = 1;
    send_word(8'h3C);
    wait_idle();

    rdy_mode = 0;
    send_word(8'hFF);
    send_word(8'h00);
    wait_idle();

    send_word(8'h80);
    wait_idle();

    // Reset after the third beat of 8'hF0: remaining bits must be dropped.
    send_word(8'hF0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 0, {7'b0, ifa.out_valid}, 8'd0);
    check("midrst_sel", 0, {5'b0, ifa.sel}, 8'd0);
    repeat (10) @(posedge clk);
    #1;

    rdy_mode = 2;
    for (int n = 0; n < 30; n++) begin
      send_word(8'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_serializer_ctrl.md
Name: mux_serializer_ctrl

Overview:
- Parallel-in/serial-out controller that sits directly upstream of the team's 8:1 bit-select mux.
- Accepts a WIDTH-bit word through a valid/ready handshake and holds it.
- Steps the select index across the word, one bit per accepted beat, and presents each bit on a valid/ready serial output.
- Exports the select index so downstream debug and scan logic can observe the bit position.

Parameters:
- WIDTH, 8, word width; power of two, at least 2.
- SEL_W, 3, select width; equals log2(WIDTH); derived, not overridden independently.
- MSB_FIRST, 0, bit order: 0 sends bit 0 first, 1 sends bit WIDTH-1 first.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_data  input  WIDTH  parallel word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- out_bit  output  1  current serial bit; equals hold_reg[sel].
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  consumer accepts out_bit this cycle.
- out_last  output  1  current bit is the final bit of the word.
- sel  output  SEL_W  current select index driving the mux.
- busy  output  1  a word is held (state SHIFT).

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values: state IDLE, hold_reg 0, sel 0 (WIDTH-1 when MSB_FIRST=1), out_valid 0, out_last 0, out_bit 0, busy 0, in_ready 1 from the first cycle after reset.
- States: IDLE and SHIFT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: capture in_data into hold_reg, load sel with the start index, go to SHIFT.
- SHIFT:
  - out_valid=1, out_bit=hold_reg[sel], busy=1.
  - out_last=1 when sel equals the end index (WIDTH-1 when LSB-first, 0 when MSB-first).
- Beat accept: a bit is consumed when out_valid && out_ready at a rising edge.
  - Not last: sel steps by +1 (LSB-first) or -1 (MSB-first).
  - Last and in_valid=1: reload hold_reg, reset sel to the start index, stay in SHIFT. This gives zero bubble between words.
  - Last and in_valid=0: go to IDLE.
- in_ready = (state==IDLE) || (state==SHIFT && out_last && out_ready). It is combinational on out_ready; there is no path from in_valid to in_ready.
- Stall: out_ready=0 holds sel, hold_reg, out_bit and out_last unchanged. out_valid never drops mid-word.
- Latency: word accepted at edge N; first bit valid in the cycle after edge N.
- Throughput: WIDTH cycles per word under continuous out_ready and in_valid.
- in_data is sampled only on an accept edge; changes at other times are ignored.
- Counter arithmetic is SEL_W bits wide; wrap at the end index never occurs because the last beat reloads or exits.
- Reset mid-word: the held word is discarded. No further bits of that word are emitted, and outputs take their reset values on the next edge.
- No X is ever driven on out_bit, including in IDLE.

Decomposition:
- Shared package holds:
  - state enum {IDLE, SHIFT};
  - a function computing the start index from MSB_FIRST and WIDTH;
  - a function computing the end index from MSB_FIRST and WIDTH.
- One sub-module: bit_select_mux, a combinational WIDTH:1 mux (inputs hold_reg and sel; output out_bit). It is instantiated inside this block so the select path matches the standalone mux stage.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, busy=0, sel=0 and in_ready=1 after release; no word captured during reset.
- Single word, LSB-first: in_data=8'hA5 and out_ready=1 held -> out_bit sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles, out_last only on the 8th, then IDLE.
- Backpressure: 8'h3C with out_ready toggling 1,0,0,1,... -> each bit held stable while stalled, sel frozen, exactly 8 accepted beats carrying 0,0,1,1,1,1,0,0.
- Back-to-back: 8'hFF then 8'h00 with in_valid held and out_ready=1 -> 16 consecutive valid beats (eight 1s then eight 0s), in_ready pulses only on the last beat of the first word, no idle cycle between words.
- Reset mid-word: assert rst_n=0 after the 3rd beat of 8'hF0 -> next cycle out_valid=0, sel=0, and the remaining 5 bits are never emitted.
- MSB_FIRST=1: in_data=8'h80 -> first out_bit=1 with sel=7, then seven 0s, out_last asserted with sel=0.
